// File: rtl/cordic_operand_sequencer.sv
// Operand sequencer for the CORDIC peripheral: converts up to two float operands through one
// shared converter, launches the core and returns status. Optional WAIT timeout: CORDIC_SEQ_TIMEOUT_EN.
module cordic_operand_sequencer #(
    parameter int unsigned FIX_W          = 18,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    output logic [31:0]      conv_fp_in,
    input  logic [FIX_W-1:0] conv_fixed,
    input  logic             conv_invalid,
    output logic             core_start,
    output logic             core_op,
    output logic [FIX_W-1:0] core_a,
    output logic [FIX_W-1:0] core_b,
    input  logic             core_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        CONV_A,
        CONV_B,
        START,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_INVALID = 2'd1,
        ERR_ILLEGAL = 2'd2,
        ERR_TIMEOUT = 2'd3
    } rsp_err_e;

    state_e            state_q, state_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              inv_q, inv_d;
    logic              inv_next;
    logic              core_op_q, core_op_d;
    logic              core_start_q, core_start_d;
    logic [FIX_W-1:0]  core_a_q, core_a_d;
    logic [FIX_W-1:0]  core_b_q, core_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    rsp_err_e          rsp_err_q, rsp_err_d;

`ifdef CORDIC_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign busy       = (state_q != IDLE);
    assign core_start = core_start_q;
    assign core_op    = core_op_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;

    always_comb begin
        conv_fp_in = '0;
        case (state_q)
            CONV_A:  conv_fp_in = a_q;
            CONV_B:  conv_fp_in = b_q;
            default: conv_fp_in = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        inv_d        = inv_q;
        inv_next     = inv_q | conv_invalid;
        core_op_d    = core_op_q;
        core_start_d = 1'b0;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
`ifdef CORDIC_SEQ_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    a_d       = cmd_a;
                    b_d       = cmd_b;
                    inv_d     = 1'b0;
                    core_op_d = cmd_op[0];
                    if (cmd_op[1]) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_ILLEGAL;
                    end else begin
                        state_d = CONV_A;
                    end
                end
            end
            // core_start is registered, so the launch decision uses the flag including this cycle's result
            CONV_A: begin
                core_a_d = conv_fixed;
                inv_d    = inv_next;
                if (core_op_q) begin
                    state_d = CONV_B;
                end else begin
                    core_b_d     = '0;
                    state_d      = START;
                    core_start_d = !inv_next;
                end
            end
            CONV_B: begin
                core_b_d     = conv_fixed;
                inv_d        = inv_next;
                state_d      = START;
                core_start_d = !inv_next;
            end
            START: begin
                if (inv_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_INVALID;
                end else begin
                    state_d = WAIT;
`ifdef CORDIC_SEQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (core_done) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_OK;
                end
`ifdef CORDIC_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            inv_q        <= 1'b0;
            core_op_q    <= 1'b0;
            core_start_q <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= ERR_OK;
`ifdef CORDIC_SEQ_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            inv_q        <= inv_d;
            core_op_q    <= core_op_d;
            core_start_q <= core_start_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
`ifdef CORDIC_SEQ_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_cordic_operand_sequencer.sv
// Directed bench for cordic_operand_sequencer with a table-based float-to-Q2.16 converter model.
module tb_cordic_operand_sequencer;

    localparam int unsigned FIX_W = 18;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [31:0]      conv_fp_in;
    logic [FIX_W-1:0] conv_fixed;
    logic             conv_invalid;
    logic             core_start;
    logic             core_op;
    logic [FIX_W-1:0] core_a;
    logic [FIX_W-1:0] core_b;
    logic             core_done;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_err;
    logic             busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int starts       = 0;
    int s0;

    always #5 clk = ~clk;

    cordic_operand_sequencer #(
        .FIX_W          (FIX_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .conv_fp_in   (conv_fp_in),
        .conv_fixed   (conv_fixed),
        .conv_invalid (conv_invalid),
        .core_start   (core_start),
        .core_op      (core_op),
        .core_a       (core_a),
        .core_b       (core_b),
        .core_done    (core_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    // {invalid, Q2.16 fixed} for the handful of floats the vectors use
    function automatic logic [FIX_W:0] conv_model(input logic [31:0] f);
        case (f)
            32'h3F800000: conv_model = {1'b0, 18'h10000};
            32'h3F000000: conv_model = {1'b0, 18'h08000};
            32'hBF000000: conv_model = {1'b0, 18'h38000};
            32'h3E800000: conv_model = {1'b0, 18'h04000};
            32'h7FC00000: conv_model = {1'b1, 18'h00000};
            default:      conv_model = {1'b0, 18'h00000};
        endcase
    endfunction

    assign {conv_invalid, conv_fixed} = conv_model(conv_fp_in);

    always @(negedge clk) if (core_start) starts++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one command across the accept edge; returns in cycle 1
    task automatic start_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        tick();
        cmd_valid = 1'b0;
        cmd_a     = 32'hDEADBEEF;
        cmd_b     = 32'hDEADBEEF;
    endtask

    task automatic finish_rsp(input logic [1:0] exp_err);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, exp_err);
        check("resp_cmd_ready", cmd_ready, 0);
        check("resp_busy", busy, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", rsp_valid, 0);
        check("post_hs_cmd_ready", cmd_ready, 1);
        check("post_hs_busy", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        core_done = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_core_start", core_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_core_a", core_a, 0);
        check("rst_core_b", core_b, 0);
        check("rst_core_op", core_op, 0);
        tick();
        rst = 1'b0;
        tick();

        // op0, A = 1.0
        s0 = starts;
        start_cmd(2'd0, 32'h3F800000, 32'h0);
        check("op0_c1_conv_in", conv_fp_in, 32'h3F800000);
        check("op0_c1_start", core_start, 0);
        check("op0_c1_busy", busy, 1);
        tick();
        check("op0_c2_start", core_start, 1);
        check("op0_c2_core_a", core_a, 18'h10000);
        check("op0_c2_core_b", core_b, 0);
        check("op0_c2_core_op", core_op, 0);
        tick();
        check("op0_c3_start", core_start, 0);
        check("op0_c3_conv_in", conv_fp_in, 0);
        repeat (4) tick();
        check("op0_c7_no_rsp", rsp_valid, 0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        finish_rsp(2'd0);
        check("op0_start_count", starts - s0, 1);

        // op1, A = 0.5, B = -0.5
        s0 = starts;
        start_cmd(2'd1, 32'h3F000000, 32'hBF000000);
        check("op1_c1_conv_in", conv_fp_in, 32'h3F000000);
        tick();
        check("op1_c2_conv_in", conv_fp_in, 32'hBF000000);
        check("op1_c2_start", core_start, 0);
        tick();
        check("op1_c3_start", core_start, 1);
        check("op1_c3_core_a", core_a, 18'h08000);
        check("op1_c3_core_b", core_b, 18'h38000);
        check("op1_c3_core_op", core_op, 1);
        tick();
        check("op1_c4_start", core_start, 0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        finish_rsp(2'd0);
        check("op1_start_count", starts - s0, 1);

        // op0 after op1: core_b cleared; response held with stray core_done
        start_cmd(2'd0, 32'h3E800000, 32'h0);
        tick();
        check("op0b_core_a", core_a, 18'h04000);
        check("op0b_core_b", core_b, 0);
        check("op0b_core_op", core_op, 0);
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            core_done = (i == 3);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_err", rsp_err, 0);
            check("hold_cmd_ready", cmd_ready, 0);
            tick();
        end
        core_done = 1'b0;
        finish_rsp(2'd0);

        // op1 with NaN B
        s0 = starts;
        start_cmd(2'd1, 32'h3F000000, 32'h7FC00000);
        tick();
        check("nan_c2_core_a", core_a, 18'h08000);
        tick();
        check("nan_c3_start", core_start, 0);
        check("nan_c3_no_rsp", rsp_valid, 0);
        tick();
        finish_rsp(2'd1);
        check("nan_start_count", starts - s0, 0);

        // illegal ops 2 and 3
        s0 = starts;
        start_cmd(2'd2, 32'h3F800000, 32'h3F800000);
        check("op2_conv_in", conv_fp_in, 0);
        check("op2_core_a_held", core_a, 18'h08000);
        finish_rsp(2'd2);
        start_cmd(2'd3, 32'h3F800000, 32'h3F800000);
        check("op3_conv_in", conv_fp_in, 0);
        finish_rsp(2'd2);
        check("illegal_start_count", starts - s0, 0);

        // stray core_done and rsp_ready while idle
        core_done = 1'b1;
        rsp_ready = 1'b1;
        tick();
        core_done = 1'b0;
        rsp_ready = 1'b0;
        tick();
        check("idle_stray_busy", busy, 0);
        check("idle_stray_rsp", rsp_valid, 0);

        // long WAIT without core_done
        start_cmd(2'd0, 32'h3F800000, 32'h0);
        tick();
`ifdef CORDIC_SEQ_TIMEOUT_EN
        repeat (8) tick();
        check("to_c10_no_rsp", rsp_valid, 0);
        tick();
        finish_rsp(2'd3);
        start_cmd(2'd0, 32'h3F800000, 32'h0);
        tick();
        repeat (8) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        finish_rsp(2'd0);
`else
        repeat (70) tick();
        check("long_wait_no_rsp", rsp_valid, 0);
        check("long_wait_busy", busy, 1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        finish_rsp(2'd0);
`endif

        // reset during WAIT
        start_cmd(2'd1, 32'h3F000000, 32'hBF000000);
        repeat (3) tick();
        check("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_core_a", core_a, 0);
        check("mid_rst_core_b", core_b, 0);
        check("mid_rst_core_op", core_op, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_err", rsp_err, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);
        repeat (5) tick();
        check("post_rst_no_rsp", rsp_valid, 0);
        start_cmd(2'd2, 32'h0, 32'h0);
        finish_rsp(2'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
